// File: rtl/lsu_pkg.sv
// Shared LSU op encodings, FSM states and op-class helpers.
// Optional misaligned-access trap is enabled with LSU_MISALIGN_TRAP_EN (see lsu.sv).
package lsu_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'h0,
        LSU_LB   = 4'h1,
        LSU_LH   = 4'h2,
        LSU_LW   = 4'h3,
        LSU_LBU  = 4'h4,
        LSU_LHU  = 4'h5,
        LSU_SB   = 4'h6,
        LSU_SH   = 4'h7,
        LSU_SW   = 4'h8
    } lsuop_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    // Encodings 1001-1111 are treated like LSU_NONE (pass-through).
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data lane select and sign/zero extension.
// Independent of LSU_MISALIGN_TRAP_EN: halfword uses a[1], word ignores a[1:0].
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [3:0]  i_lsuop,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift = i_rdata >> {i_addr_lo, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data  = '0;
        case (i_lsuop)
            LSU_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LSU_LH:  o_data = {{16{w_half[15]}}, w_half};
            LSU_LW:  o_data = i_rdata;
            LSU_LBU: o_data = {24'h0, w_byte};
            LSU_LHU: o_data = {16'h0, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one transaction on a valid/ready data bus, result handed to WBU.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned LH/LHU/SH/LW/SW without a bus request.
module lsu
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_exu_valid,
    output logic        o_lsu_ready,
    input  logic [3:0]  i_exu_lsuop,
    input  logic [31:0] i_exu_aluout,
    input  logic [31:0] i_exu_rs2_data,
    input  logic [3:0]  i_exu_rd,
    input  logic        i_exu_wen,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_lsu_valid,
    input  logic        i_wbu_ready,
    output logic [3:0]  o_lsu_rd,
    output logic        o_lsu_wen,
    output logic [31:0] o_lsu_wdata,
    output logic        o_lsu_err
);

    state_e      r_state, w_next;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;
    logic [3:0]  r_rd;
    logic        r_wen;
    logic [31:0] r_result;
    logic        r_err;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_misalign;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wmask;
    logic [31:0] w_load_data;

    assign w_accept   = (r_state == S_IDLE) && i_exu_valid;
    assign w_is_mem   = is_mem_op(i_exu_lsuop);
    assign w_is_store = is_store_op(i_exu_lsuop);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign =
        (((i_exu_lsuop == LSU_LH) || (i_exu_lsuop == LSU_LHU) || (i_exu_lsuop == LSU_SH))
            && i_exu_aluout[0]) ||
        (((i_exu_lsuop == LSU_LW) || (i_exu_lsuop == LSU_SW))
            && (i_exu_aluout[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_st_wdata = '0;
        w_st_wmask = '0;
        case (i_exu_lsuop)
            LSU_SB: begin
                w_st_wdata = {4{i_exu_rs2_data[7:0]}};
                w_st_wmask = 4'b0001 << i_exu_aluout[1:0];
            end
            LSU_SH: begin
                w_st_wdata = {2{i_exu_rs2_data[15:0]}};
                w_st_wmask = i_exu_aluout[1] ? 4'b1100 : 4'b0011;
            end
            LSU_SW: begin
                w_st_wdata = i_exu_rs2_data;
                w_st_wmask = 4'b1111;
            end
            default: ;
        endcase
    end

    lsu_load_align u_load_align (
        .i_rdata   (i_mem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_lsuop   (r_op),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_exu_valid) w_next = (w_is_mem && !w_misalign) ? S_REQ : S_DONE;
            S_REQ:  if (i_mem_req_ready) w_next = S_WAIT;
            S_WAIT: if (i_mem_resp_valid) w_next = S_DONE;
            S_DONE: if (i_wbu_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Result defaults to the ALU value so pass-through and trap cases need no extra path.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_op        <= '0;
            r_addr      <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_rd        <= '0;
            r_wen       <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_op        <= i_exu_lsuop;
            r_addr      <= i_exu_aluout;
            r_mem_wdata <= w_st_wdata;
            r_mem_wmask <= w_st_wmask;
            r_rd        <= i_exu_rd;
            r_wen       <= i_exu_wen && !w_is_store && !w_misalign;
            r_result    <= i_exu_aluout;
            r_err       <= w_misalign;
        end else if ((r_state == S_WAIT) && i_mem_resp_valid && !is_store_op(r_op)) begin
            r_result    <= w_load_data;
        end
    end

    assign o_lsu_ready     = (r_state == S_IDLE);
    assign o_mem_req_valid = (r_state == S_REQ);
    assign o_lsu_valid     = (r_state == S_DONE);
    assign o_mem_addr      = {r_addr[31:2], 2'b00};
    assign o_mem_wen       = is_store_op(r_op);
    assign o_mem_wdata     = r_mem_wdata;
    assign o_mem_wmask     = r_mem_wmask;
    assign o_lsu_rd        = r_rd;
    assign o_lsu_wen       = r_wen;
    assign o_lsu_wdata     = r_result;
    assign o_lsu_err       = r_err;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a behavioural model of the op rules.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_exu_valid;
    logic        o_lsu_ready;
    logic [3:0]  i_exu_lsuop;
    logic [31:0] i_exu_aluout;
    logic [31:0] i_exu_rs2_data;
    logic [3:0]  i_exu_rd;
    logic        i_exu_wen;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_rdata;
    logic        o_lsu_valid;
    logic        i_wbu_ready;
    logic [3:0]  o_lsu_rd;
    logic        o_lsu_wen;
    logic [31:0] o_lsu_wdata;
    logic        o_lsu_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    lsu dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_exu_valid      (i_exu_valid),
        .o_lsu_ready      (o_lsu_ready),
        .i_exu_lsuop      (i_exu_lsuop),
        .i_exu_aluout     (i_exu_aluout),
        .i_exu_rs2_data   (i_exu_rs2_data),
        .i_exu_rd         (i_exu_rd),
        .i_exu_wen        (i_exu_wen),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wen        (o_mem_wen),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_wmask      (o_mem_wmask),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_rdata      (i_mem_rdata),
        .o_lsu_valid      (o_lsu_valid),
        .i_wbu_ready      (i_wbu_ready),
        .o_lsu_rd         (o_lsu_rd),
        .o_lsu_wen        (o_lsu_wen),
        .o_lsu_wdata      (o_lsu_wdata),
        .o_lsu_err        (o_lsu_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One instruction end to end; the bus and WBU delays are cycle counts chosen by the caller.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [3:0] rd, input logic wen, input logic [31:0] rdata,
                          input int unsigned req_lat, input int unsigned resp_lat,
                          input int unsigned wbu_lat);
        logic        is_mem, is_st, mis, exp_wen;
        logic [31:0] b, h, exp_data, exp_wdata;
        logic [3:0]  exp_mask;

        is_mem = (op >= 4'd1) && (op <= 4'd8);
        is_st  = (op >= 4'd6) && (op <= 4'd8);
        mis    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((op == 4'd2 || op == 4'd5 || op == 4'd7) && (addr % 2 != 0)) mis = 1'b1;
        if ((op == 4'd3 || op == 4'd8) && (addr % 4 != 0)) mis = 1'b1;
`endif
        b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        h = ((addr % 4) >= 2) ? (rdata >> 16) : (rdata & 32'hFFFF);
        case (op)
            4'd1:    exp_data = (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            4'd2:    exp_data = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            4'd3:    exp_data = rdata;
            4'd4:    exp_data = b;
            4'd5:    exp_data = h;
            default: exp_data = addr;
        endcase
        if (mis) exp_data = addr;
        exp_wen = wen && !is_st && !mis;
        if (op == 4'd6) begin
            exp_wdata = (rs2 & 32'hFF) * 32'h0101_0101;
            exp_mask  = 4'(1 << (addr % 4));
        end else if (op == 4'd7) begin
            exp_wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
            exp_mask  = ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
        end else begin
            exp_wdata = rs2;
            exp_mask  = 4'b1111;
        end

        @(negedge i_clk);
        chk("idle_ready", {31'h0, o_lsu_ready}, 32'h1);
        i_exu_valid    = 1'b1;
        i_exu_lsuop    = op;
        i_exu_aluout   = addr;
        i_exu_rs2_data = rs2;
        i_exu_rd       = rd;
        i_exu_wen      = wen;
        @(negedge i_clk);
        i_exu_valid    = 1'b0;
        i_exu_lsuop    = 4'($urandom);
        i_exu_aluout   = $urandom;
        i_exu_rs2_data = $urandom;
        i_exu_rd       = 4'($urandom);
        i_exu_wen      = 1'($urandom);

        if (is_mem && !mis) begin
            for (int i = 0; i <= int'(req_lat); i++) begin
                chk("req_valid", {31'h0, o_mem_req_valid}, 32'h1);
                chk("req_addr", o_mem_addr, {addr[31:2], 2'b00});
                chk("req_wen", {31'h0, o_mem_wen}, {31'h0, is_st});
                if (is_st) begin
                    chk("req_wdata", o_mem_wdata, exp_wdata);
                    chk("req_wmask", {28'h0, o_mem_wmask}, {28'h0, exp_mask});
                end
                chk("early_valid", {31'h0, o_lsu_valid}, 32'h0);
                if (i == int'(req_lat)) i_mem_req_ready = 1'b1;
                @(negedge i_clk);
                i_mem_req_ready = 1'b0;
            end
            for (int i = 1; i <= int'(resp_lat); i++) begin
                chk("req_drop", {31'h0, o_mem_req_valid}, 32'h0);
                chk("wait_valid", {31'h0, o_lsu_valid}, 32'h0);
                if (i == int'(resp_lat)) begin
                    i_mem_resp_valid = 1'b1;
                    i_mem_rdata      = rdata;
                end
                @(negedge i_clk);
                i_mem_resp_valid = 1'b0;
                i_mem_rdata      = $urandom;
            end
        end else begin
            chk("no_req", {31'h0, o_mem_req_valid}, 32'h0);
        end

        for (int i = 0; i <= int'(wbu_lat); i++) begin
            chk("done_valid", {31'h0, o_lsu_valid}, 32'h1);
            chk("done_rd", {28'h0, o_lsu_rd}, {28'h0, rd});
            chk("done_wen", {31'h0, o_lsu_wen}, {31'h0, exp_wen});
            chk("done_err", {31'h0, o_lsu_err}, {31'h0, mis});
            if (!is_st || mis) chk("done_wdata", o_lsu_wdata, exp_data);
            chk("done_busy", {31'h0, o_lsu_ready}, 32'h0);
            chk("done_noreq", {31'h0, o_mem_req_valid}, 32'h0);
            if (i == int'(wbu_lat)) begin
                i_wbu_ready = 1'b1;
                i_exu_valid = 1'b0;
            end else begin
                i_exu_valid      = 1'($urandom);
                i_exu_lsuop      = 4'($urandom);
                i_mem_resp_valid = 1'($urandom);
                i_mem_rdata      = $urandom;
            end
            @(negedge i_clk);
            i_wbu_ready      = 1'b0;
            i_mem_resp_valid = 1'b0;
            i_exu_valid      = 1'b0;
        end
        chk("release_valid", {31'h0, o_lsu_valid}, 32'h0);
        chk("release_ready", {31'h0, o_lsu_ready}, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {19'h0, o_mem_req_valid, o_mem_wen, o_mem_wmask, o_lsu_valid,
                            o_lsu_rd, o_lsu_wen, o_lsu_err}, 32'h0);
        chk({tag, "_data"}, o_mem_addr | o_mem_wdata | o_lsu_wdata, 32'h0);
        chk({tag, "_ready"}, {31'h0, o_lsu_ready}, 32'h1);
    endtask

    initial begin
        i_rst            = 1'b0;
        i_exu_valid      = 1'b0;
        i_exu_lsuop      = '0;
        i_exu_aluout     = '0;
        i_exu_rs2_data   = '0;
        i_exu_rd         = '0;
        i_exu_wen        = 1'b0;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = '0;
        i_wbu_ready      = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge i_clk);
        i_rst = 1'b1;

        run_op(4'd0, 32'h1234_5678, 32'h0, 4'd5, 1'b1, 32'h0, 0, 1, 0);
        run_op(4'd1, 32'h8000_0003, 32'h0, 4'd6, 1'b1, 32'h80FF_0000, 2, 3, 0);
        run_op(4'd4, 32'h8000_0003, 32'h0, 4'd7, 1'b1, 32'h80FF_0000, 2, 3, 0);
        run_op(4'd5, 32'h8000_0002, 32'h0, 4'd8, 1'b1, 32'h80FF_0000, 2, 3, 0);
        run_op(4'd7, 32'h8000_0002, 32'hAAAA_BEEF, 4'd9, 1'b1, 32'h0, 0, 1, 0);
        run_op(4'd3, 32'h8000_0004, 32'h0, 4'd3, 1'b1, 32'hCAFE_F00D, 0, 1, 4);
        run_op(4'd3, 32'h8000_0002, 32'h0, 4'd4, 1'b1, 32'h1357_9BDF, 0, 1, 0);
        run_op(4'd12, 32'h0BAD_F00D, 32'h0, 4'd0, 1'b1, 32'h0, 0, 1, 1);

        // Reset while waiting for a load response.
        @(negedge i_clk);
        i_exu_valid  = 1'b1;
        i_exu_lsuop  = 4'd3;
        i_exu_aluout = 32'h8000_0010;
        i_exu_rd     = 4'd2;
        i_exu_wen    = 1'b1;
        @(negedge i_clk);
        i_exu_valid     = 1'b0;
        i_mem_req_ready = 1'b1;
        @(negedge i_clk);
        i_mem_req_ready = 1'b0;
        chk("pre_reset_addr", o_mem_addr, 32'h8000_0010);
        #2;
        i_rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge i_clk);
        i_rst = 1'b1;
        run_op(4'd3, 32'h8000_0020, 32'h0, 4'd1, 1'b1, 32'h0F1E_2D3C, 0, 1, 0);

        for (int n = 0; n < 200; n++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 4'($urandom), 1'($urandom),
                   $urandom, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
